// File: rtl/instr_result_checker.sv
// instr_result_checker: read-back checker for the 32-entry instruction register.
// Walks a pointer range, fetches each stored word, recomputes the expected
// result from opcode and operands, and reports the per-entry verdict and running totals.
//
// Handshake: a scan request is `start` while the checker is idle (fsm in IDLE
// and `busy` low). It is accepted on that clock edge, and `busy` rises on the
// next cycle. While `busy` is high, including the `done` cycle, `start` is
// ignored. `check_valid` and `done` are single-cycle pulses with no
// back-pressure. The payload outputs (check_ptr, check_pass, div_zero,
// expected_result) are qualified by `check_valid`.
module instr_result_checker #(
  parameter int PTR_W = 5,
  parameter int OP_W  = 32,
  parameter int RES_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PTR_W-1:0]          first_ptr,
  input  logic [PTR_W-1:0]          last_ptr,
  output logic [PTR_W-1:0]          read_pointer,
  input  logic [4+2*OP_W+RES_W-1:0] instruction_word,
  output logic                      busy,
  output logic                      done,
  output logic                      check_valid,
  output logic [PTR_W-1:0]          check_ptr,
  output logic                      check_pass,
  output logic                      div_zero,
  output logic [RES_W-1:0]          expected_result,
  output logic [PTR_W:0]            pass_count,
  output logic [PTR_W:0]            err_count,
  output logic [2:0]                fsm_state
);

  localparam int WORD_W = 4 + 2*OP_W + RES_W;
  localparam int CNT_W  = $clog2(OP_W);

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_CAPT   = 3'd2,
    S_EXEC   = 3'd3,
    S_DIVIDE = 3'd4,
    S_CHECK  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // scan bookkeeping
  logic [PTR_W-1:0] ptr, last_q;

  // captured instruction word
  logic [3:0]       opc_q;
  logic [OP_W-1:0]  a_q, b_q;
  logic [RES_W-1:0] res_q;

  // single-cycle result and divider state
  logic [RES_W-1:0] calc_q;
  logic [OP_W-1:0]  rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] div_cnt;

  // FSM control strobes
  logic accept, capture, exec_en, div_en, check_fire, done_fire;

  // datapath combinational terms
  logic             is_divop, b_zero, need_div, last_hit, div_last, pass_now;
  logic [RES_W-1:0] a_ext, b_ext, simple_res, q_ext, r_ext, div_res, final_res;
  logic [OP_W-1:0]  a_mag, b_mag;
  logic [OP_W:0]    rem_sh;
  logic             rem_ge;

  assign fsm_state = state;

  assign is_divop = (opc_q == OPC_DIV) || (opc_q == OPC_MOD);
  assign b_zero   = (b_q == '0);
  assign need_div = is_divop && !b_zero;
  assign last_hit = (ptr == last_q);
  assign div_last = (div_cnt == CNT_W'(OP_W-1));

  assign a_ext = {{(RES_W-OP_W){a_q[OP_W-1]}}, a_q};
  assign b_ext = {{(RES_W-OP_W){b_q[OP_W-1]}}, b_q};

  // Divider runs on magnitudes; the most negative operand maps to 2^(OP_W-1) unsigned.
  assign a_mag = a_q[OP_W-1] ? (~a_q + 1'b1) : a_q;
  assign b_mag = b_q[OP_W-1] ? (~b_q + 1'b1) : b_q;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh = {rem_q, quo_q[OP_W-1]};
  assign rem_ge = (rem_sh >= {1'b0, dvs_q});

  // Quotient sign is a^b, remainder sign follows the dividend.
  assign q_ext   = {{(RES_W-OP_W){1'b0}}, quo_q};
  assign r_ext   = {{(RES_W-OP_W){1'b0}}, rem_q};
  assign div_res = (opc_q == OPC_DIV)
                   ? ((a_q[OP_W-1] ^ b_q[OP_W-1]) ? (~q_ext + 1'b1) : q_ext)
                   : (a_q[OP_W-1] ? (~r_ext + 1'b1) : r_ext);

  assign final_res = need_div ? div_res : calc_q;
  // Opcodes 8..15 never pass; their expected value stays 0.
  assign pass_now  = !opc_q[3] && (res_q == final_res);

  // Single-cycle results for all non-divider opcodes
  always_comb begin
    simple_res = '0;
    case (opc_q)
      OPC_ZERO:  simple_res = '0;
      OPC_PASSA: simple_res = a_ext;
      OPC_PASSB: simple_res = b_ext;
      OPC_ADD:   simple_res = a_ext + b_ext;
      OPC_SUB:   simple_res = a_ext - b_ext;
      OPC_MULT:  simple_res = a_ext * b_ext;
      default:   simple_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ADDR;
      S_ADDR:   state_nxt = S_CAPT;
      S_CAPT:   state_nxt = S_EXEC;
      S_EXEC:   state_nxt = need_div ? S_DIVIDE : S_CHECK;
      S_DIVIDE: if (div_last) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = last_hit ? S_IDLE : S_ADDR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    accept     = (state == S_IDLE) && start && !busy;
    capture    = (state == S_CAPT);
    exec_en    = (state == S_EXEC);
    div_en     = (state == S_DIVIDE);
    check_fire = (state == S_CHECK);
    done_fire  = check_fire && last_hit;
  end

  // Scan pointer, range latch, busy flag and read address
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= '0;
      last_q       <= '0;
      busy         <= 1'b0;
      read_pointer <= '0;
    end else begin
      if (accept) begin
        ptr    <= first_ptr;
        last_q <= last_ptr;
        busy   <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (state == S_ADDR) read_pointer <= ptr;
      if (check_fire && !last_hit) ptr <= ptr + 1'b1;
    end
  end

  // Capture the fetched word, then compute or seed the divider
  always_ff @(posedge clk) begin
    if (reset) begin
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      calc_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      div_cnt <= '0;
    end else begin
      if (capture) begin
        opc_q <= instruction_word[WORD_W-1 -: 4];
        a_q   <= instruction_word[2*OP_W+RES_W-1 -: OP_W];
        b_q   <= instruction_word[OP_W+RES_W-1 -: OP_W];
        res_q <= instruction_word[RES_W-1:0];
      end
      if (exec_en) begin
        calc_q  <= simple_res;
        rem_q   <= '0;
        quo_q   <= a_mag;
        dvs_q   <= b_mag;
        div_cnt <= '0;
      end
      if (div_en) begin
        rem_q   <= rem_ge ? (rem_sh[OP_W-1:0] - dvs_q) : rem_sh[OP_W-1:0];
        quo_q   <= {quo_q[OP_W-2:0], rem_ge};
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Report the verdict and update the running totals
  always_ff @(posedge clk) begin
    if (reset) begin
      check_valid     <= 1'b0;
      done            <= 1'b0;
      check_ptr       <= '0;
      check_pass      <= 1'b0;
      div_zero        <= 1'b0;
      expected_result <= '0;
      pass_count      <= '0;
      err_count       <= '0;
    end else begin
      check_valid <= check_fire;
      done        <= done_fire;
      if (accept) begin
        pass_count <= '0;
        err_count  <= '0;
      end
      if (check_fire) begin
        check_ptr       <= ptr;
        check_pass      <= pass_now;
        div_zero        <= is_divop && b_zero;
        expected_result <= final_res;
        if (pass_now) pass_count <= pass_count + 1'b1;
        else          err_count  <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_result_checker.sv
// tb_instr_result_checker: directed table vectors, hand-written corner
// sequences and randomized scans against an arithmetic reference model.
module tb_instr_result_checker;

  localparam int EXP_W = 72;   // {ptr[4:0], pass, dz, slow, result[63:0]}
  localparam int LIMIT = 1300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start;
  logic [4:0]   first_ptr, last_ptr, read_pointer, check_ptr;
  logic [131:0] instruction_word;
  logic         busy, done, check_valid, check_pass, div_zero;
  logic [63:0]  expected_result;
  logic [5:0]   pass_count, err_count;
  logic [2:0]   fsm_state;

  logic [131:0] mem [0:31];
  assign instruction_word = mem[read_pointer];

  instr_result_checker dut (
    .clk(clk), .reset(reset), .start(start),
    .first_ptr(first_ptr), .last_ptr(last_ptr),
    .read_pointer(read_pointer), .instruction_word(instruction_word),
    .busy(busy), .done(done), .check_valid(check_valid),
    .check_ptr(check_ptr), .check_pass(check_pass), .div_zero(div_zero),
    .expected_result(expected_result),
    .pass_count(pass_count), .err_count(err_count),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EXP_W-1:0] model(input logic [4:0] p, input logic [131:0] w);
    logic [3:0] opc;
    longint sa, sb, stored, r;
    bit dz, slow, ok;
    opc = w[131:128];
    sa = $signed(w[127:96]);
    sb = $signed(w[95:64]);
    stored = w[63:0];
    r = 0; dz = 0; slow = 0; ok = 1;
    case (opc)
      4'd0: r = 0;
      4'd1: r = sa;
      4'd2: r = sb;
      4'd3: r = sa + sb;
      4'd4: r = sa - sb;
      4'd5: r = sa * sb;
      4'd6, 4'd7: begin
        if (sb == 0) dz = 1;
        else begin
          slow = 1;
          r = (opc == 4'd6) ? sa / sb : sa % sb;
        end
      end
      default: ok = 0;
    endcase
    return {p, ok && (stored == r), dz, slow, r};
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20)) - 32'd10;
      1:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver: one scan, checked against exp_q ----------------
  task automatic run_scan(input logic [4:0] f, input logic [4:0] l,
                          input bit poke_busy, input bit poke_done);
    int n_exp, pass_exp, cyc, prev, stray;
    bit seen_done;
    logic [EXP_W-1:0] e;
    n_exp = exp_q.size();
    pass_exp = 0;
    foreach (exp_q[i]) pass_exp += int'(exp_q[i][66]);
    start = 1'b1; first_ptr = f; last_ptr = l;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; prev = 1; seen_done = 0;
    chk("busy_after_start", busy, 1);
    while (!seen_done && cyc < LIMIT) begin
      if (poke_busy && cyc == 2) begin
        start = 1'b1; first_ptr = f + 5'd3; last_ptr = l + 5'd3;
      end
      if (poke_busy && cyc == 3) start = 1'b0;
      if (check_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_check_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("check_ptr", check_ptr, e[71:67]);
          chk("check_pass", check_pass, e[66]);
          chk("div_zero", div_zero, e[65]);
          chk("expected_result", expected_result, e[63:0]);
          chk("check_latency", cyc - prev, e[64] ? 36 : 4);
          chk("done_with_last", done, exp_q.size() == 0);
          prev = cyc;
        end
      end else if (done) begin
        chk("done_without_check", 1, 0);
      end
      if (done) begin
        seen_done = 1;
        if (poke_done) begin
          start = 1'b1; first_ptr = f + 5'd1; last_ptr = l + 5'd1;
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen_done) begin
      chk("scan_timeout", cyc, 0);
      exp_q.delete();
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("pass_count", pass_count, pass_exp);
    chk("err_count", err_count, n_exp - pass_exp);
    chk("queue_drained", exp_q.size(), 0);
    if (poke_done) begin
      stray = 0;
      repeat (6) begin
        @(negedge clk);
        if (busy || check_valid || done) stray++;
      end
      chk("start_on_done_ignored", stray, 0);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [4:0]  ptr;
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic [63:0] exp_res;
    logic        exp_pass;
    logic        exp_dz;
  } tvec_t;

  tvec_t tv[20];

  function automatic bit slow_op(input logic [3:0] opc, input logic [31:0] b);
    return (opc == 4'd6 || opc == 4'd7) && (b != 0);
  endfunction

  task automatic push_tv(input int i);
    mem[tv[i].ptr] = {tv[i].opc, tv[i].a, tv[i].b, tv[i].res};
    exp_q.push_back({tv[i].ptr, tv[i].exp_pass, tv[i].exp_dz,
                     slow_op(tv[i].opc, tv[i].b), tv[i].exp_res});
  endtask

  initial begin
    int stray;
    logic [4:0] f, l, p;
    logic [3:0] opc;
    logic [31:0] a, b;
    logic [63:0] r;
    logic [EXP_W-1:0] e;
    int n;

    tv[0]  = '{5'd0,  4'd3, 32'd5,  32'd7, 64'd12, 64'd12, 1'b1, 1'b0};
    tv[1]  = '{5'd0,  4'd0, -32'sd7, 32'd2, 64'd0,     64'd0,     1'b1, 1'b0};
    tv[2]  = '{5'd1,  4'd1, -32'sd7, 32'd2, -64'sd7,   -64'sd7,   1'b1, 1'b0};
    tv[3]  = '{5'd2,  4'd2, -32'sd7, 32'd2, 64'd2,     64'd2,     1'b1, 1'b0};
    tv[4]  = '{5'd3,  4'd3, -32'sd7, 32'd2, -64'sd5,   -64'sd5,   1'b1, 1'b0};
    tv[5]  = '{5'd4,  4'd4, -32'sd7, 32'd2, -64'sd9,   -64'sd9,   1'b1, 1'b0};
    tv[6]  = '{5'd5,  4'd5, -32'sd7, 32'd2, -64'sd14,  -64'sd14,  1'b1, 1'b0};
    tv[7]  = '{5'd6,  4'd6, -32'sd7, 32'd2, -64'sd3,   -64'sd3,   1'b1, 1'b0};
    tv[8]  = '{5'd7,  4'd7, -32'sd7, 32'd2, -64'sd1,   -64'sd1,   1'b1, 1'b0};
    tv[9]  = '{5'd3,  4'd5, 32'd3,  32'd4, 64'd13, 64'd12, 1'b0, 1'b0};
    tv[10] = '{5'd5,  4'd6, 32'd9,  32'd0, 64'd0,  64'd0,  1'b1, 1'b1};
    tv[11] = '{5'd5,  4'd6, 32'd9,  32'd0, 64'd1,  64'd0,  1'b0, 1'b1};
    tv[12] = '{5'd9,  4'd7, -32'sd5, 32'd0, 64'd0, 64'd0,  1'b1, 1'b1};
    tv[13] = '{5'd12, 4'd9, 32'd1,  32'd1, 64'd0,  64'd0,  1'b0, 1'b0};
    tv[14] = '{5'd31, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 1'b1, 1'b0};
    tv[15] = '{5'd17, 4'd5, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b0};
    tv[16] = '{5'd20, 4'd4, 32'h8000_0000, 32'h7FFF_FFFF,
               64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0001, 1'b1, 1'b0};
    tv[17] = '{5'd21, 4'd7, 32'd7,    -32'sd2, 64'd1,     64'd1,     1'b1, 1'b0};
    tv[18] = '{5'd22, 4'd6, -32'sd100, 32'd7,  -64'sd14,  -64'sd14,  1'b1, 1'b0};
    tv[19] = '{5'd23, 4'd7, -32'sd100, 32'd7,  -64'sd2,   -64'sd2,   1'b1, 1'b0};

    for (int i = 0; i < 32; i++) mem[i] = '0;
    start = 1'b0; first_ptr = '0; last_ptr = '0;

    // reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_check_valid", check_valid, 0);
    chk("rst_read_pointer", read_pointer, 0);
    chk("rst_expected", expected_result, 0);
    chk("rst_pass_count", pass_count, 0);
    chk("rst_err_count", err_count, 0);

    // single-entry table vectors
    for (int i = 0; i < 20; i++) begin
      push_tv(i);
      run_scan(tv[i].ptr, tv[i].ptr, 0, 0);
    end

    // ZERO..MOD in entries 0..7, one scan, with a start poked while busy
    for (int i = 1; i <= 8; i++) push_tv(i);
    run_scan(5'd0, 5'd7, 1, 0);

    // wrap-around 30,31,0,1 with a start coinciding with done
    for (int k = 0; k < 4; k++) begin
      p = 5'd30 + 5'(k);
      mem[p] = {4'd3, 32'(k), 32'd10, 64'(k + 10)};
      exp_q.push_back(model(p, mem[p]));
    end
    run_scan(5'd30, 5'd1, 0, 1);

    // reset in the middle of the DIVIDE of entry 6
    for (int i = 1; i <= 8; i++) mem[tv[i].ptr] = {tv[i].opc, tv[i].a, tv[i].b, tv[i].res};
    start = 1'b1; first_ptr = 5'd0; last_ptr = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    chk("pass_count_mid_scan", pass_count, 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_check_valid", check_valid, 0);
    chk("midrst_read_pointer", read_pointer, 0);
    chk("midrst_pass_count", pass_count, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_expected", expected_result, 0);
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || check_valid || busy) stray++;
    end
    chk("midrst_quiet", stray, 0);
    push_tv(0);
    run_scan(5'd0, 5'd0, 0, 0);

    // randomized scans against the model
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 32; i++) begin
        opc = 4'($urandom_range(0, 9));
        a = rnd_op();
        b = ($urandom_range(0, 5) == 0) ? 32'd0 : rnd_op();
        e = model(5'(i), {opc, a, b, 64'd0});
        r = ($urandom_range(0, 3) != 0) ? e[63:0] : {$urandom(), $urandom()};
        mem[i] = {opc, a, b, r};
      end
      f = 5'($urandom_range(0, 31));
      l = 5'($urandom_range(0, 31));
      n = int'(5'(l - f)) + 1;
      for (int k = 0; k < n; k++) begin
        p = f + 5'(k);
        exp_q.push_back(model(p, mem[p]));
      end
      run_scan(f, l, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
